calc_seq_ctrl: RTL

Sequencer for the calculator operand/operator datapath. Decodes keypad events into the entry sequence operand A, operator, operand B, equals. Drives the load strobes of the two 4-bit operand registers and the operator select, then hands off to the ALU with a start/done handshake. Sits between the keypad debouncer and the operand registers/ALU.

---
 rtl/calc_pkg.sv | 27 ++
 rtl/calc_timeout_cnt.sv | 33 +++
 rtl/calc_seq_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared types for the calculator entry sequencer: key classes, operator codes, FSM states.
package calc_pkg;

  typedef enum logic [1:0] {
    KEY_DIGIT = 2'd0,
    KEY_OP    = 2'd1,
    KEY_EQ    = 2'd2,
    KEY_CLR   = 2'd3
  } key_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GOT_A  = 3'd1,
    S_GOT_OP = 3'd2,
    S_GOT_B  = 3'd3,
    S_EXEC   = 3'd4,
    S_SHOW   = 3'd5
  } state_e;

endpackage

// File: rtl/calc_timeout_cnt.sv
// Loadable down-counter bounding the ALU wait; o_expire_c is high during the final counted cycle.
module calc_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic CLK,
  input  logic reset,
  input  logic i_clear,
  input  logic i_start,
  output logic o_expire_c
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] r_cnt;
  logic          r_run;

  // Counter stops itself once it reaches zero so expiry fires only once per start.
  always_ff @(posedge CLK) begin
    if (reset || i_clear) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_start) begin
      r_cnt <= CW'(TIMEOUT_CYC - 1);
      r_run <= 1'b1;
    end else if (r_run) begin
      if (r_cnt == '0) r_run <= 1'b0;
      else             r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_expire_c = r_run && (r_cnt == '0);

endmodule

// File: rtl/calc_seq_ctrl.sv
// Keypad-driven entry sequencer (A, operator, B, equals) with ALU start/done handshake and timeout.
// Optional build macro CALC_CHAIN_EN: an operator key while a result is shown reuses that result as A.
module calc_seq_ctrl
  import calc_pkg::*;
#(
  parameter int unsigned W           = 4,
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         key_valid,
  input  logic [1:0]   key_type,
  input  logic [W-1:0] key_data,
  input  logic         alu_done,
  input  logic [W-1:0] alu_result,
  output logic         ld_a,
  output logic         ld_b,
  output logic [W-1:0] d_out,
  output logic [1:0]   op_sel,
  output logic         alu_start,
  output logic [W-1:0] result,
  output logic         result_valid,
  output logic         busy,
  output logic         err
);

  state_e r_state;
  key_e   w_key;
  logic   w_is_clr;
  logic   w_cnt_start;
  logic   w_cnt_clear;
  logic   w_expire_c;

  assign w_key       = key_e'(key_type);
  assign w_is_clr    = key_valid && (w_key == KEY_CLR);
  assign w_cnt_start = key_valid && (w_key == KEY_EQ) && (r_state == S_GOT_B);
  assign w_cnt_clear = w_is_clr || ((r_state == S_EXEC) && alu_done);

  calc_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .CLK        (CLK),
    .reset      (reset),
    .i_clear    (w_cnt_clear),
    .i_start    (w_cnt_start),
    .o_expire_c (w_expire_c)
  );

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state      <= S_IDLE;
      ld_a         <= 1'b0;
      ld_b         <= 1'b0;
      d_out        <= '0;
      op_sel       <= 2'(OP_ADD);
      alu_start    <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
    end else begin
      ld_a      <= 1'b0;
      ld_b      <= 1'b0;
      alu_start <= 1'b0;
      if (w_is_clr) begin
        r_state      <= S_IDLE;
        op_sel       <= 2'(OP_ADD);
        result       <= '0;
        result_valid <= 1'b0;
        busy         <= 1'b0;
        err          <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_GOT_A: begin
            if (key_valid && w_key == KEY_DIGIT) begin
              ld_a    <= 1'b1;
              d_out   <= key_data;
              r_state <= S_GOT_A;
            end else if (key_valid && w_key == KEY_OP && r_state == S_GOT_A) begin
              op_sel  <= key_data[1:0];
              r_state <= S_GOT_OP;
            end
          end
          S_GOT_OP, S_GOT_B: begin
            if (key_valid && w_key == KEY_DIGIT) begin
              ld_b    <= 1'b1;
              d_out   <= key_data;
              r_state <= S_GOT_B;
            end else if (key_valid && w_key == KEY_OP && r_state == S_GOT_OP) begin
              op_sel <= key_data[1:0];
            end else if (key_valid && w_key == KEY_EQ && r_state == S_GOT_B) begin
              alu_start <= 1'b1;
              busy      <= 1'b1;
              r_state   <= S_EXEC;
            end
          end
          S_EXEC: begin
            // A done arriving on the last allowed cycle still counts as success.
            if (alu_done) begin
              result       <= alu_result;
              result_valid <= 1'b1;
              busy         <= 1'b0;
              r_state      <= S_SHOW;
            end else if (w_expire_c) begin
              err     <= 1'b1;
              busy    <= 1'b0;
              r_state <= S_IDLE;
            end
          end
          S_SHOW: begin
            if (key_valid && w_key == KEY_DIGIT) begin
              ld_a         <= 1'b1;
              d_out        <= key_data;
              result_valid <= 1'b0;
              r_state      <= S_GOT_A;
            end
`ifdef CALC_CHAIN_EN
            else if (key_valid && w_key == KEY_OP) begin
              ld_a         <= 1'b1;
              d_out        <= result;
              op_sel       <= key_data[1:0];
              result_valid <= 1'b0;
              r_state      <= S_GOT_OP;
            end
`endif
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
